// File: rtl/truth_table_sweeper.sv
// Exhaustive stimulus driver and response checker for y = a'bd' + bc + bd'.
// Steps abcd through all 16 vectors, samples yWire after a settle delay and scores it against EXPECTED.
module truth_table_sweeper #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [15:0] EXPECTED      = 16'hD0D0
) (
  input  logic        clkWire,
  input  logic        rstWire,
  input  logic        startWire,
  input  logic        yWire,
  output logic        aWire,
  output logic        bWire,
  output logic        cWire,
  output logic        dWire,
  output logic        busyWire,
  output logic        doneWire,
  output logic        passWire,
  output logic [15:0] tableWire,
  output logic [4:0]  errCountWire,
  output logic [3:0]  firstErrWire,
  output logic        errValidWire
);

  localparam logic [7:0] SETTLE = 8'(SETTLE_CYCLES);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  vec_q, vec_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic [15:0] table_q, table_d;
  logic [4:0]  err_cnt_q, err_cnt_d;
  logic [3:0]  first_err_q, first_err_d;
  logic        err_valid_q, err_valid_d;
  logic        mismatch;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    vec_d       = vec_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    table_d     = table_q;
    err_cnt_d   = err_cnt_q;
    first_err_d = first_err_q;
    err_valid_d = err_valid_q;
    mismatch    = 1'b0;

    case (state_q)
      IDLE: begin
        vec_d  = 4'd0;
        busy_d = 1'b0;
        if (startWire) begin
          state_d     = RUN;
          table_d     = 16'd0;
          err_cnt_d   = 5'd0;
          first_err_d = 4'd0;
          err_valid_d = 1'b0;
          pass_d      = 1'b0;
          idx_d       = 4'd0;
          cnt_d       = SETTLE;
          busy_d      = 1'b1;
        end
      end
      RUN: begin
        busy_d = 1'b1;
        // cnt_q == 1 marks the last cycle the current vector is held: sample now
        if (cnt_q <= 8'd1) begin
          mismatch       = (yWire != EXPECTED[idx_q]);
          table_d[idx_q] = yWire;
          if (mismatch) begin
            err_cnt_d = err_cnt_q + 5'd1;
            if (!err_valid_q) begin
              first_err_d = idx_q;
              err_valid_d = 1'b1;
            end
          end
          cnt_d = SETTLE;
          if (idx_q == 4'd15) begin
            state_d = DONE;
            vec_d   = 4'd0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_cnt_d == 5'd0);
          end else begin
            idx_d = idx_q + 4'd1;
            vec_d = idx_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clkWire) begin
    if (rstWire) begin
      state_q     <= IDLE;
      idx_q       <= 4'd0;
      cnt_q       <= 8'd0;
      vec_q       <= 4'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      table_q     <= 16'd0;
      err_cnt_q   <= 5'd0;
      first_err_q <= 4'd0;
      err_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      vec_q       <= vec_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      table_q     <= table_d;
      err_cnt_q   <= err_cnt_d;
      first_err_q <= first_err_d;
      err_valid_q <= err_valid_d;
    end
  end

  assign aWire        = vec_q[3];
  assign bWire        = vec_q[2];
  assign cWire        = vec_q[1];
  assign dWire        = vec_q[0];
  assign busyWire     = busy_q;
  assign doneWire     = done_q;
  assign passWire     = pass_q;
  assign tableWire    = table_q;
  assign errCountWire = err_cnt_q;
  assign firstErrWire = first_err_q;
  assign errValidWire = err_valid_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: two instances (S=2 and S=1) each driving a behavioural DUT model
// that can be correct, stuck-at-0, inverted, or missing the bc term.
module tb_truth_table_sweeper;

  localparam int M_OK   = 0;
  localparam int M_SA0  = 1;
  localparam int M_INV  = 2;
  localparam int M_NOBC = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start2 = 1'b0, start1 = 1'b0;
  int   mode2 = M_OK, mode1 = M_OK;
  bit   use_s1 = 1'b0;

  logic y2, a2, b2, c2, d2, busy2, done2, pass2, valid2;
  logic [15:0] tab2;
  logic [4:0]  ec2;
  logic [3:0]  fe2;
  logic y1, a1, b1, c1, d1, busy1, done1, pass1, valid1;
  logic [15:0] tab1;
  logic [4:0]  ec1;
  logic [3:0]  fe1;

  logic [3:0]  vec_m, fe_m;
  logic        busy_m, done_m, pass_m, valid_m;
  logic [15:0] tab_m;
  logic [4:0]  ec_m;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  function automatic logic model_y(input int mode, input logic a, b, c, d);
    logic good;
    good = (~a & b & ~d) | (b & c) | (b & ~d);
    case (mode)
      M_SA0:   return 1'b0;
      M_INV:   return ~good;
      M_NOBC:  return b & ~d;
      default: return good;
    endcase
  endfunction

  assign y2 = model_y(mode2, a2, b2, c2, d2);
  assign y1 = model_y(mode1, a1, b1, c1, d1);

  truth_table_sweeper #(.SETTLE_CYCLES(2), .EXPECTED(16'hD0D0)) u_dut2 (
    .clkWire(clk), .rstWire(rst), .startWire(start2), .yWire(y2),
    .aWire(a2), .bWire(b2), .cWire(c2), .dWire(d2),
    .busyWire(busy2), .doneWire(done2), .passWire(pass2), .tableWire(tab2),
    .errCountWire(ec2), .firstErrWire(fe2), .errValidWire(valid2)
  );

  truth_table_sweeper #(.SETTLE_CYCLES(1), .EXPECTED(16'hD0D0)) u_dut1 (
    .clkWire(clk), .rstWire(rst), .startWire(start1), .yWire(y1),
    .aWire(a1), .bWire(b1), .cWire(c1), .dWire(d1),
    .busyWire(busy1), .doneWire(done1), .passWire(pass1), .tableWire(tab1),
    .errCountWire(ec1), .firstErrWire(fe1), .errValidWire(valid1)
  );

  always_comb begin
    vec_m   = use_s1 ? {a1, b1, c1, d1} : {a2, b2, c2, d2};
    busy_m  = use_s1 ? busy1  : busy2;
    done_m  = use_s1 ? done1  : done2;
    pass_m  = use_s1 ? pass1  : pass2;
    valid_m = use_s1 ? valid1 : valid2;
    tab_m   = use_s1 ? tab1   : tab2;
    ec_m    = use_s1 ? ec1    : ec2;
    fe_m    = use_s1 ? fe1    : fe2;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_vec"},   32'(vec_m),   32'd0);
    check({tag, "_busy"},  32'(busy_m),  32'd0);
    check({tag, "_done"},  32'(done_m),  32'd0);
    check({tag, "_pass"},  32'(pass_m),  32'd0);
    check({tag, "_table"}, 32'(tab_m),   32'd0);
    check({tag, "_ec"},    32'(ec_m),    32'd0);
    check({tag, "_fe"},    32'(fe_m),    32'd0);
    check({tag, "_valid"}, 32'(valid_m), 32'd0);
  endtask

  // restart_at > 0: raise start again at edge E0+restart_at and keep it high through DONE
  task automatic run_sweep(input string tag, input bit s1, input int mode,
                           input logic [15:0] exp_tab, input logic [4:0] exp_ec,
                           input logic [3:0] exp_fe, input bit exp_v, input bit exp_p,
                           input int restart_at);
    int s;
    int n;
    bit seen;
    s = s1 ? 1 : 2;
    use_s1 = s1;
    if (s1) mode1 = mode; else mode2 = mode;
    if (s1) start1 = 1'b1; else start2 = 1'b1;
    tick();
    start1 = 1'b0;
    start2 = 1'b0;
    check({tag, "_busy_e0"}, 32'(busy_m), 32'd1);
    check({tag, "_vec_e0"},  32'(vec_m),  32'd0);
    for (int k = 1; k < 16 * s; k++) begin
      tick();
      if (k % s == 0) check({tag, "_vec"}, 32'(vec_m), 32'(k / s));
      if (done_m) check({tag, "_early_done"}, 32'(done_m), 32'd0);
      if (restart_at > 0 && k == restart_at - 1) start2 = 1'b1;
    end
    tick();
    check({tag, "_done"},  32'(done_m),  32'd1);
    check({tag, "_busy_end"}, 32'(busy_m), 32'd0);
    check({tag, "_vec_end"}, 32'(vec_m), 32'd0);
    check({tag, "_table"}, 32'(tab_m),   32'(exp_tab));
    check({tag, "_ec"},    32'(ec_m),    32'(exp_ec));
    check({tag, "_fe"},    32'(fe_m),    32'(exp_fe));
    check({tag, "_valid"}, 32'(valid_m), 32'(exp_v));
    check({tag, "_pass"},  32'(pass_m),  32'(exp_p));
    tick();
    check({tag, "_done_pulse"}, 32'(done_m), 32'd0);
    check({tag, "_busy_idle"},  32'(busy_m), 32'd0);
    check({tag, "_hold_table"}, 32'(tab_m),  32'(exp_tab));
    check({tag, "_hold_pass"},  32'(pass_m), 32'(exp_p));
    if (restart_at > 0) begin
      tick();
      start2 = 1'b0;
      check({tag, "_re_busy"},  32'(busy_m), 32'd1);
      check({tag, "_re_table"}, 32'(tab_m),  32'd0);
      check({tag, "_re_ec"},    32'(ec_m),   32'd0);
      check({tag, "_re_pass"},  32'(pass_m), 32'd0);
      seen = 1'b0;
      n = 0;
      while (!seen && n < 100) begin
        tick();
        n++;
        seen = done_m;
      end
      check({tag, "_re_done_seen"}, 32'(seen), 32'd1);
      check({tag, "_re_done_time"}, 32'(n),    32'(16 * s));
      check({tag, "_re_table2"},    32'(tab_m), 32'(16'hD0D0));
      check({tag, "_re_pass2"},     32'(pass_m), 32'd1);
      tick();
    end
  endtask

  initial begin
    bit seen;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    use_s1 = 1'b0;
    check_idle_zero("rst2");
    use_s1 = 1'b1;
    check_idle_zero("rst1");
    tick();

    run_sweep("ok_s2",   1'b0, M_OK,   16'hD0D0, 5'd0,  4'd0, 1'b0, 1'b1, 0);
    run_sweep("sa0_s2",  1'b0, M_SA0,  16'h0000, 5'd6,  4'd4, 1'b1, 1'b0, 0);
    run_sweep("inv_s1",  1'b1, M_INV,  16'h2F2F, 5'd16, 4'd0, 1'b1, 1'b0, 0);
    run_sweep("nobc_s2", 1'b0, M_NOBC, 16'h5050, 5'd2,  4'd7, 1'b1, 1'b0, 0);
    run_sweep("restart", 1'b0, M_OK,   16'hD0D0, 5'd0,  4'd0, 1'b0, 1'b1, 5);

    // reset while vector 7 is driven, after a faulty partial sweep has logged errors
    use_s1 = 1'b0;
    mode2 = M_SA0;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    repeat (14) tick();
    check("midrst_vec7", 32'(vec_m), 32'd7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle_zero("midrst");
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (done_m || busy_m) seen = 1'b1;
    end
    check("midrst_quiet", 32'(seen), 32'd0);
    run_sweep("after_rst", 1'b0, M_OK, 16'hD0D0, 5'd0, 4'd0, 1'b0, 1'b1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
Exhaustive stimulus driver and response checker for the 4-input minimized-logic block y = a'bd' + bc + bd'. This block drives the DUT's four input wires through all 16 combinations and samples the DUT output after a settle delay. It records the captured truth table and compares it against an expected 16-bit mask. It sits beside the combinational DUT on the board/top level and reports pass/fail, error count and the first failing vector.

Parameters:
SETTLE_CYCLES, 2, cycles between driving a vector and sampling yWire; legal 1..255 (8-bit internal counter)
EXPECTED, 16'hD0D0, expected truth table; bit i = y for vector i, where i = {a,b,c,d} (a = MSB)

Ports:
clkWire  input  1  system clock; all logic on rising edge
rstWire  input  1  synchronous, active-high reset
startWire  input  1  level; begins a sweep when sampled high in IDLE
yWire  input  1  DUT output (outWire of the minimized circuit)
aWire  output  1  DUT input a = vector index bit 3
bWire  output  1  DUT input b = vector index bit 2
cWire  output  1  DUT input c = vector index bit 1
dWire  output  1  DUT input d = vector index bit 0
busyWire  output  1  high while a sweep is in progress
doneWire  output  1  one-cycle pulse at sweep completion
passWire  output  1  1 when the last completed sweep had zero mismatches
tableWire  output  16  captured truth table, bit i = sampled yWire for vector i
errCountWire  output  5  number of mismatching vectors (0..16)
firstErrWire  output  4  index of the lowest mismatching vector
errValidWire  output  1  firstErrWire is meaningful (at least one mismatch)

Behaviour:
- Single clock domain (clkWire). Reset is synchronous and active-high on rstWire. All outputs are registered.
- Reset values: every output 0; state = IDLE; vector index 0; settle counter 0.
- States: IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - a/b/c/d driven 0; busyWire = 0.
  - startWire = 1 at edge E0 enters RUN and clears tableWire, errCountWire, firstErrWire, errValidWire and passWire.
  - At the same edge E0: index = 0, settle counter loaded, vector 0 driven.
- RUN:
  - busyWire = 1.
  - The vector for index i is driven from edge E0+i*S until edge E0+(i+1)*S, where S = SETTLE_CYCLES.
  - At edge E0+(i+1)*S:
    - tableWire[i] <= yWire.
    - If yWire != EXPECTED[i]: errCountWire increments. If errValidWire = 0, firstErrWire <= i and errValidWire <= 1.
    - If i < 15: index increments and the next vector is driven.
    - If i = 15: go to DONE, a/b/c/d <= 0, busyWire <= 0.
- DONE:
  - Lasts exactly one cycle, with doneWire = 1.
  - passWire = (final errCount == 0), registered with doneWire.
  - Then returns to IDLE.
  - Total sweep: done asserted during the cycle after edge E0+16*S.
- Results hold after DONE until the next accepted start or reset.
- startWire is ignored in RUN and DONE. No queuing.
- If startWire is held high continuously, a new sweep starts on the first IDLE cycle after DONE.
- Mismatch count in the final sample cycle includes vector 15. passWire uses the fully updated count.
- Reset mid-sweep:
  - Returns to reset values at the next edge.
  - No doneWire pulse.
  - Partial results are discarded.
- errCountWire saturates naturally at 16; 5 bits are required.
- yWire is sampled only at sample edges; glitches between samples are ignored.

Test Plan:
- Correct DUT model, S=2, start pulse at E0 -> abcd steps 0..15, each held 2 cycles; done pulse at E0+32; tableWire=16'hD0D0, errCount=0, errValid=0, pass=1.
- DUT stuck-at-0 on y, S=2 -> tableWire=0, errCount=6, firstErr=4, errValid=1, pass=0.
- DUT output inverted, S=1 -> tableWire=16'h2F2F, errCount=16, firstErr=0, pass=0; done at E0+16.
- Faulty DUT missing the bc term (y = bd'), S=2 -> tableWire=16'h5050, errCount=2, firstErr=7, pass=0.
- startWire pulsed again at E0+5 and held high through DONE -> mid-run start has no effect and timing is unchanged; a second sweep starts at the first IDLE cycle after done; results are cleared at that start edge.
- rstWire asserted for 1 cycle while vector 7 is driven -> next edge all outputs 0, state IDLE, no done pulse; a subsequent start yields the full correct result of scenario 1.
